// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard/stall bundle between the pipeline datapath and the hazard controller.
// master: pipeline side driving hazard inputs; slave: the controller.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_a_wr;
    logic       ex_RegWrite;
    logic [1:0] ex_result_src;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       err_clr;
    logic       pc_stall;
    logic       stall_ifid;
    logic       stall_idex;
    logic       stall_exmem;
    logic       flush_ifid;
    logic       flush_idex;
    logic       flush_memwb;
    logic       mem_abort;
    logic       timeout_err;
    logic [1:0] state;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_a_wr, ex_RegWrite, ex_result_src,
        output ex_branch_taken, mem_req, mem_ready, err_clr,
        input  pc_stall, stall_ifid, stall_idex, stall_exmem,
        input  flush_ifid, flush_idex, flush_memwb,
        input  mem_abort, timeout_err, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_a_wr, ex_RegWrite, ex_result_src,
        input  ex_branch_taken, mem_req, mem_ready, err_clr,
        output pc_stall, stall_ifid, stall_idex, stall_exmem,
        output flush_ifid, flush_idex, flush_memwb,
        output mem_abort, timeout_err, state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use, taken branch, and wait-state
// peripheral accesses with timeout abort.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        WAIT  = 2'b01,
        ABORT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             err, set_err;
    logic             lu, mh;

    assign lu = hz.ex_RegWrite && (hz.ex_result_src == 2'b01) &&
                (hz.ex_a_wr != 5'd0) &&
                ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_a_wr)) ||
                 (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_a_wr)));
    assign mh = hz.mem_req && !hz.mem_ready;

    assign hz.state       = st;
    assign hz.timeout_err = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= RUN;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
            if (set_err)
                err <= 1'b1;
            else if (hz.err_clr)
                err <= 1'b0;
        end
    end

    always_comb begin
        st_nx          = st;
        cnt_nx         = cnt;
        set_err        = 1'b0;
        hz.pc_stall    = 1'b0;
        hz.stall_ifid  = 1'b0;
        hz.stall_idex  = 1'b0;
        hz.stall_exmem = 1'b0;
        hz.flush_ifid  = 1'b0;
        hz.flush_idex  = 1'b0;
        hz.flush_memwb = 1'b0;
        hz.mem_abort   = 1'b0;
        if (rst) begin
            // Bubbles everywhere so pipeline registers clear alongside us
            hz.flush_ifid  = 1'b1;
            hz.flush_idex  = 1'b1;
            hz.flush_memwb = 1'b1;
            st_nx          = RUN;
            cnt_nx         = '0;
        end else begin
            unique case (st)
                RUN: begin
                    if (mh) begin
                        hz.pc_stall    = 1'b1;
                        hz.stall_ifid  = 1'b1;
                        hz.stall_idex  = 1'b1;
                        hz.stall_exmem = 1'b1;
                        hz.flush_memwb = 1'b1;
                        st_nx          = WAIT;
                        cnt_nx         = CNT_W'(1);
                    end else if (hz.ex_branch_taken) begin
                        hz.flush_ifid = 1'b1;
                        hz.flush_idex = 1'b1;
                    end else if (lu) begin
                        hz.pc_stall   = 1'b1;
                        hz.stall_ifid = 1'b1;
                        hz.flush_idex = 1'b1;
                    end
                end
                WAIT: begin
                    if (hz.mem_ready) begin
                        st_nx  = RUN;
                        cnt_nx = '0;
                        if (hz.ex_branch_taken) begin
                            hz.flush_ifid = 1'b1;
                            hz.flush_idex = 1'b1;
                        end else if (lu) begin
                            hz.pc_stall   = 1'b1;
                            hz.stall_ifid = 1'b1;
                            hz.flush_idex = 1'b1;
                        end
                    end else begin
                        hz.pc_stall    = 1'b1;
                        hz.stall_ifid  = 1'b1;
                        hz.stall_idex  = 1'b1;
                        hz.stall_exmem = 1'b1;
                        hz.flush_memwb = 1'b1;
                        if (cnt == CNT_TO)
                            st_nx = ABORT;
                        else if (cnt != CNT_MAX)
                            cnt_nx = cnt + 1'b1;
                    end
                end
                ABORT: begin
                    hz.mem_abort   = 1'b1;
                    hz.flush_memwb = 1'b1;
                    set_err        = 1'b1;
                    cnt_nx         = '0;
                    st_nx          = RUN;
                end
                default: begin
                    st_nx  = RUN;
                    cnt_nx = '0;
                end
            endcase
        end
    end
endmodule
